// File: rtl/mem_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package mem_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    // Timeout counter width; at least one bit so a disabled timeout still elaborates.
    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch/data ports and memory port of the arbiter, bundled as one interface.
interface mem_arbiter_if;

    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_valid;
    logic [31:0] o_if_rdata;

    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [1:0]  i_d_size;
    logic [31:0] i_d_wdata;
    logic        o_d_valid;
    logic [31:0] o_d_rdata;
    logic        o_d_err;

    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_size, i_d_wdata,
        input  i_mem_ready, i_mem_rdata,
        output o_if_valid, o_if_rdata, o_d_valid, o_d_rdata, o_d_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata
    );

    modport master (
        output i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_size, i_d_wdata,
        output i_mem_ready, i_mem_rdata,
        input  o_if_valid, o_if_rdata, o_d_valid, o_d_rdata, o_d_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: size/offset to strobes, store replication, load alignment.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_aligned,
    output logic        misaligned
);

    logic [31:0] shifted_s;

    assign shifted_s = mem_rdata >> {addr_lo, 3'b000};

    // Per-size lane decode; size 00 is reported as misaligned so it gets an error response.
    always_comb begin
        wstrb         = 4'b0000;
        wdata_rep     = 32'h0000_0000;
        rdata_aligned = 32'h0000_0000;
        misaligned    = 1'b0;
        case (size)
            SZ_BYTE: begin
                wstrb         = 4'b0001 << addr_lo;
                wdata_rep     = {4{wdata[7:0]}};
                rdata_aligned = {24'h00_0000, shifted_s[7:0]};
            end
            SZ_HALF: begin
                wstrb         = 4'b0011 << addr_lo;
                wdata_rep     = {2{wdata[15:0]}};
                rdata_aligned = {16'h0000, shifted_s[15:0]};
                misaligned    = addr_lo[0];
            end
            SZ_WORD: begin
                wstrb         = 4'b1111;
                wdata_rep     = wdata;
                rdata_aligned = shifted_s;
                misaligned    = (addr_lo != 2'b00);
            end
            default: begin
                misaligned    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory between CPU fetch and data ports.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int TMO_W = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_r, state_n;
    logic               prefer_d_r, prefer_d_n;
    logic [TMO_W-1:0]   cnt_r, cnt_n;
    logic [1:0]         d_size_r, d_size_n, d_lo_r, d_lo_n;
    logic               mem_req_r, mem_req_n, mem_we_r, mem_we_n;
    logic [31:0]        mem_addr_r, mem_addr_n, mem_wdata_r, mem_wdata_n;
    logic [3:0]         mem_wstrb_r, mem_wstrb_n;
    logic               if_valid_r, if_valid_n, d_valid_r, d_valid_n, d_err_r, d_err_n;
    logic [31:0]        if_rdata_r, if_rdata_n, d_rdata_r, d_rdata_n;

    logic               if_req_s, d_req_s, grant_d_s, grant_if_s, timed_out_s, exit_s;
    logic [1:0]         sel_size_s, sel_lo_s;
    logic [3:0]         wstrb_s;
    logic [31:0]        wdata_rep_s, rdata_aligned_s;
    logic               misaligned_s;
    logic               unused_s;

    assign unused_s = ^bus.i_if_addr[1:0];

    // A requester whose valid is showing this cycle is still holding its old request.
    assign if_req_s   = bus.i_if_req & ~if_valid_r;
    assign d_req_s    = bus.i_d_req & ~d_valid_r;
    assign grant_d_s  = d_req_s & (~if_req_s | prefer_d_r);
    assign grant_if_s = if_req_s & ~grant_d_s;
    assign timed_out_s = (TIMEOUT != 0) && (cnt_r == TMO_LAST);

    // Lanes decode live inputs in IDLE and the captured attributes while the access runs.
    assign sel_size_s = (state_r == D_BUSY) ? d_size_r : bus.i_d_size;
    assign sel_lo_s   = (state_r == D_BUSY) ? d_lo_r   : bus.i_d_addr[1:0];

    mem_lane_align u_lane (
        .size          (sel_size_s),
        .addr_lo       (sel_lo_s),
        .wdata         (bus.i_d_wdata),
        .mem_rdata     (bus.i_mem_rdata),
        .wstrb         (wstrb_s),
        .wdata_rep     (wdata_rep_s),
        .rdata_aligned (rdata_aligned_s),
        .misaligned    (misaligned_s)
    );

    // Next-state, grant, and registered-output computation.
    always_comb begin
        state_n     = state_r;
        prefer_d_n  = prefer_d_r;
        cnt_n       = cnt_r;
        d_size_n    = d_size_r;
        d_lo_n      = d_lo_r;
        mem_req_n   = mem_req_r;
        mem_we_n    = mem_we_r;
        mem_addr_n  = mem_addr_r;
        mem_wstrb_n = mem_wstrb_r;
        mem_wdata_n = mem_wdata_r;
        if_valid_n  = 1'b0;
        if_rdata_n  = 32'h0000_0000;
        d_valid_n   = 1'b0;
        d_rdata_n   = 32'h0000_0000;
        d_err_n     = 1'b0;
        exit_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    prefer_d_n = 1'b0;
                    if (misaligned_s) begin
                        d_valid_n = 1'b1;
                        d_err_n   = 1'b1;
                    end else begin
                        state_n     = D_BUSY;
                        cnt_n       = {TMO_W{1'b0}};
                        d_size_n    = bus.i_d_size;
                        d_lo_n      = bus.i_d_addr[1:0];
                        mem_req_n   = 1'b1;
                        mem_we_n    = bus.i_d_we;
                        mem_addr_n  = {bus.i_d_addr[31:2], 2'b00};
                        mem_wstrb_n = wstrb_s;
                        mem_wdata_n = bus.i_d_we ? wdata_rep_s : 32'h0000_0000;
                    end
                end else if (grant_if_s) begin
                    prefer_d_n  = 1'b1;
                    state_n     = IF_BUSY;
                    cnt_n       = {TMO_W{1'b0}};
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = {bus.i_if_addr[31:2], 2'b00};
                    mem_wstrb_n = 4'b1111;
                    mem_wdata_n = 32'h0000_0000;
                end else begin
                    state_n = IDLE;
                end
            end
            IF_BUSY: begin
                if (bus.i_mem_ready) begin
                    if_valid_n = 1'b1;
                    if_rdata_n = bus.i_mem_rdata;
                    exit_s     = 1'b1;
                end else if (timed_out_s) begin
                    if_valid_n = 1'b1;
                    exit_s     = 1'b1;
                end else begin
                    cnt_n = cnt_r + TMO_W'(1);
                end
            end
            D_BUSY: begin
                if (bus.i_mem_ready) begin
                    d_valid_n = 1'b1;
                    d_rdata_n = mem_we_r ? 32'h0000_0000 : rdata_aligned_s;
                    exit_s    = 1'b1;
                end else if (timed_out_s) begin
                    d_valid_n = 1'b1;
                    d_err_n   = 1'b1;
                    exit_s    = 1'b1;
                end else begin
                    cnt_n = cnt_r + TMO_W'(1);
                end
            end
            default: begin
                exit_s = 1'b1;
            end
        endcase
        if (exit_s) begin
            state_n     = IDLE;
            mem_req_n   = 1'b0;
            mem_we_n    = 1'b0;
            mem_addr_n  = 32'h0000_0000;
            mem_wstrb_n = 4'b0000;
            mem_wdata_n = 32'h0000_0000;
        end else begin
            exit_s = 1'b0;
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= IDLE;
            prefer_d_r  <= 1'b1;
            cnt_r       <= {TMO_W{1'b0}};
            d_size_r    <= 2'b00;
            d_lo_r      <= 2'b00;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            if_valid_r  <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            d_valid_r   <= 1'b0;
            d_rdata_r   <= 32'h0000_0000;
            d_err_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            prefer_d_r  <= prefer_d_n;
            cnt_r       <= cnt_n;
            d_size_r    <= d_size_n;
            d_lo_r      <= d_lo_n;
            mem_req_r   <= mem_req_n;
            mem_we_r    <= mem_we_n;
            mem_addr_r  <= mem_addr_n;
            mem_wstrb_r <= mem_wstrb_n;
            mem_wdata_r <= mem_wdata_n;
            if_valid_r  <= if_valid_n;
            if_rdata_r  <= if_rdata_n;
            d_valid_r   <= d_valid_n;
            d_rdata_r   <= d_rdata_n;
            d_err_r     <= d_err_n;
        end
    end

    assign bus.o_if_valid  = if_valid_r;
    assign bus.o_if_rdata  = if_rdata_r;
    assign bus.o_d_valid   = d_valid_r;
    assign bus.o_d_rdata   = d_rdata_r;
    assign bus.o_d_err     = d_err_r;
    assign bus.o_mem_req   = mem_req_r;
    assign bus.o_mem_we    = mem_we_r;
    assign bus.o_mem_addr  = mem_addr_r;
    assign bus.o_mem_wstrb = mem_wstrb_r;
    assign bus.o_mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations (TIMEOUT = 4).
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [1:0]  bad_size [3] = '{2'b11, 2'b10, 2'b00};
    logic [31:0] bad_addr [3] = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0000};

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_if_req    = 1'b0;
        bus.i_if_addr   = 32'h0000_0000;
        bus.i_d_req     = 1'b0;
        bus.i_d_we      = 1'b0;
        bus.i_d_addr    = 32'h0000_0000;
        bus.i_d_size    = 2'b00;
        bus.i_d_wdata   = 32'h0000_0000;
        bus.i_mem_ready = 1'b0;
        bus.i_mem_rdata = 32'h0000_0000;
    endtask

    initial begin
        logic [31:0] vld;
        logic [31:0] rd;

        idle_inputs();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
        check("rst_d_valid", 32'(bus.o_d_valid), 32'd0);
        check("rst_if_valid", 32'(bus.o_if_valid), 32'd0);
        check("rst_mem_addr", bus.o_mem_addr, 32'h0000_0000);
        check("rst_wstrb", 32'(bus.o_mem_wstrb), 32'h0);
        rst_n = 1'b1;

        // Store byte at 0x103
        bus.i_d_req = 1'b1; bus.i_d_we = 1'b1; bus.i_d_addr = 32'h0000_0103;
        bus.i_d_size = 2'b01; bus.i_d_wdata = 32'h0000_00AB;
        check("st_req_c0", 32'(bus.o_mem_req), 32'd0);
        tick();
        check("st_req_c1", 32'(bus.o_mem_req), 32'd1);
        check("st_we", 32'(bus.o_mem_we), 32'd1);
        check("st_addr", bus.o_mem_addr, 32'h0000_0100);
        check("st_wstrb", 32'(bus.o_mem_wstrb), 32'h8);
        check("st_wdata", bus.o_mem_wdata, 32'hABAB_ABAB);
        check("st_valid_c1", 32'(bus.o_d_valid), 32'd0);
        bus.i_mem_ready = 1'b1;
        tick();
        check("st_valid_c2", 32'(bus.o_d_valid), 32'd1);
        check("st_err_c2", 32'(bus.o_d_err), 32'd0);
        check("st_req_c2", 32'(bus.o_mem_req), 32'd0);
        idle_inputs();
        tick();
        check("st_valid_c3", 32'(bus.o_d_valid), 32'd0);

        // Load half at 0x202; ready already high in IDLE must be ignored
        bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_addr = 32'h0000_0202;
        bus.i_d_size = 2'b10; bus.i_mem_ready = 1'b1; bus.i_mem_rdata = 32'hBEEF_1234;
        tick();
        check("ld_req", 32'(bus.o_mem_req), 32'd1);
        check("ld_we", 32'(bus.o_mem_we), 32'd0);
        check("ld_addr", bus.o_mem_addr, 32'h0000_0200);
        check("ld_wstrb", 32'(bus.o_mem_wstrb), 32'hC);
        check("ld_valid_c1", 32'(bus.o_d_valid), 32'd0);
        tick();
        check("ld_valid_c2", 32'(bus.o_d_valid), 32'd1);
        check("ld_rdata", bus.o_d_rdata, 32'h0000_BEEF);
        check("ld_err", 32'(bus.o_d_err), 32'd0);
        idle_inputs();
        tick();

        // Error responses: misaligned word, misaligned half, size 00
        for (int i = 0; i < 3; i++) begin
            bus.i_d_req = 1'b1; bus.i_d_we = 1'b0;
            bus.i_d_size = bad_size[i]; bus.i_d_addr = bad_addr[i];
            tick();
            check($sformatf("bad%0d_mem_req", i), 32'(bus.o_mem_req), 32'd0);
            check($sformatf("bad%0d_valid", i), 32'(bus.o_d_valid), 32'd1);
            check($sformatf("bad%0d_err", i), 32'(bus.o_d_err), 32'd1);
            check($sformatf("bad%0d_rdata", i), bus.o_d_rdata, 32'h0000_0000);
            idle_inputs();
            tick();
            check($sformatf("bad%0d_after", i), 32'(bus.o_d_valid), 32'd0);
        end

        // Timeout after 4 BUSY cycles, data port then fetch port
        for (int p = 0; p < 2; p++) begin
            if (p == 0) begin
                bus.i_d_req = 1'b1; bus.i_d_we = 1'b0;
                bus.i_d_addr = 32'h0000_0010; bus.i_d_size = 2'b11;
            end else begin
                bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0014;
            end
            bus.i_mem_rdata = 32'hDEAD_BEEF;
            for (int c = 1; c <= 4; c++) begin
                tick();
                vld = (p == 0) ? 32'(bus.o_d_valid) : 32'(bus.o_if_valid);
                check($sformatf("tmo%0d_busy_c%0d", p, c), 32'(bus.o_mem_req), 32'd1);
                check($sformatf("tmo%0d_novalid_c%0d", p, c), vld, 32'd0);
            end
            tick();
            vld = (p == 0) ? 32'(bus.o_d_valid) : 32'(bus.o_if_valid);
            rd  = (p == 0) ? bus.o_d_rdata : bus.o_if_rdata;
            check($sformatf("tmo%0d_valid", p), vld, 32'd1);
            check($sformatf("tmo%0d_rdata", p), rd, 32'h0000_0000);
            check($sformatf("tmo%0d_idle", p), 32'(bus.o_mem_req), 32'd0);
            if (p == 0) begin
                check("tmo0_err", 32'(bus.o_d_err), 32'd1);
            end
            idle_inputs();
            tick();
        end

        // Reset in the second BUSY cycle
        bus.i_d_req = 1'b1; bus.i_d_we = 1'b1; bus.i_d_addr = 32'h0000_0020;
        bus.i_d_size = 2'b11; bus.i_d_wdata = 32'h0000_0055;
        tick();
        tick();
        check("mid_busy", 32'(bus.o_mem_req), 32'd1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("mid_rst_req", 32'(bus.o_mem_req), 32'd0);
        check("mid_rst_we", 32'(bus.o_mem_we), 32'd0);
        check("mid_rst_addr", bus.o_mem_addr, 32'h0000_0000);
        check("mid_rst_wstrb", 32'(bus.o_mem_wstrb), 32'h0);
        check("mid_rst_wdata", bus.o_mem_wdata, 32'h0000_0000);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("post_rst_valid_c%0d", c), 32'(bus.o_d_valid), 32'd0);
            check($sformatf("post_rst_req_c%0d", c), 32'(bus.o_mem_req), 32'd0);
        end

        // Contention from reset pointer: D, IF, D, IF with one valid every 2 cycles
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h0000_0400;
        bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_addr = 32'h0000_0800;
        bus.i_d_size = 2'b11; bus.i_mem_ready = 1'b1; bus.i_mem_rdata = 32'h1122_3344;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("arb%0d_addr", k), bus.o_mem_addr,
                  (k % 2 == 0) ? 32'h0000_0800 : 32'h0000_0400);
            check($sformatf("arb%0d_gap_d", k), 32'(bus.o_d_valid), 32'd0);
            check($sformatf("arb%0d_gap_if", k), 32'(bus.o_if_valid), 32'd0);
            tick();
            check($sformatf("arb%0d_d_valid", k), 32'(bus.o_d_valid),
                  (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("arb%0d_if_valid", k), 32'(bus.o_if_valid),
                  (k % 2 == 0) ? 32'd0 : 32'd1);
            rd = (k % 2 == 0) ? bus.o_d_rdata : bus.o_if_rdata;
            check($sformatf("arb%0d_rdata", k), rd, 32'h1122_3344);
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that lets the CPU's instruction-fetch port and load/store port share one single-ported, word-wide memory. It sits between the CPU and the memory model/BRAM. It sequences each access with a request/valid handshake and converts the CPU's byte/half/word size code into byte strobes and aligned read data. A timeout guards against a memory that never answers.

## Interface
- TIMEOUT, 255: cycles to wait for i_mem_ready before aborting; 0 disables the timeout.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_if_req  in  1  fetch request; held with i_if_addr until o_if_valid.
- i_if_addr  in  32  fetch address; bits [1:0] are ignored.
- o_if_valid  out  1  one-cycle pulse: fetch complete.
- o_if_rdata  out  32  fetched word; valid only while o_if_valid is high.
- i_d_req  in  1  data request; held with its attributes until o_d_valid.
- i_d_we  in  1  1 = store, 0 = load.
- i_d_addr  in  32  byte address.
- i_d_size  in  2  01 = byte, 10 = half, 11 = word, 00 = no access.
- i_d_wdata  in  32  store data, LSB-justified.
- o_d_valid  out  1  one-cycle pulse: data access complete.
- o_d_rdata  out  32  load data shifted to the LSB, upper bytes zero (the CPU extends the value).
- o_d_err  out  1  qualifies o_d_valid: misaligned access, size 00, or timeout.
- o_mem_req  out  1  memory access in progress.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  32  word address; bits [1:0] are forced to 0.
- o_mem_wstrb  out  4  byte strobes, bit n = byte lane n.
- o_mem_wdata  out  32  store data replicated across the lanes.
- i_mem_ready  in  1  memory has accepted or completed the access this cycle.
- i_mem_rdata  in  32  read word; valid when i_mem_ready is high.

## Operation
- FSM states:
  - IDLE: o_mem_req = 0.
  - IF_BUSY and D_BUSY: o_mem_req = 1, with o_mem_* registered on entry and held stable until exit.
- Transitions out of IDLE:
  - One request only: grant it.
  - Both requests: round-robin. Grant the requester that did not win the previous grant.
  - Pointer reset value favours data.
- Exit from BUSY:
  - On i_mem_ready = 1, capture i_mem_rdata and go to IDLE.
  - In the same edge, register the matching valid pulse.
- Masking: during the cycle its valid is high, the completing requester's req is ignored. A new request from it is recognised from the next cycle.
- Alignment check on the data port, evaluated in IDLE:
  - An error case is any of: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 00.
  - On error, do not enter D_BUSY. Pulse o_d_valid with o_d_err = 1 on the next cycle, and set o_d_rdata = 0.
  - An error response still counts as a grant for round-robin.
- Strobes:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - Loads drive the same strobe pattern, and o_mem_we = 0.
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Read data: i_mem_rdata >> (8 × addr[1:0]), masked to the access size. Fetches return the raw word.
- Timeout:
  - A counter clears on entry to BUSY and increments each cycle i_mem_ready = 0.
  - When it reaches TIMEOUT, go to IDLE and pulse valid with rdata = 0.
  - For data, also assert o_d_err. Fetch has no error flag; a fetch timeout returns 0, which the CPU treats as an illegal instruction.

## Timing
- Reset value of every output is 0. Reset also sets state = IDLE, the round-robin pointer = data-first, and timeout counter = 0.
- Reset mid-access aborts the access immediately. No valid pulse is produced, and the memory side drops o_mem_req asynchronously.
- Best-case latency (req high in cycle 0, ready in cycle 1): o_mem_req in cycle 1, valid in cycle 2.
- Back-to-back accesses: at most one access completes per 2 cycles.
- Simultaneous requests: both are served in alternating order.
- i_mem_ready while in IDLE is ignored.

## Structure
- Package mem_pkg holds:
  - size constants SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum {IDLE, IF_BUSY, D_BUSY};
  - the width of the timeout counter, $clog2(TIMEOUT+1).
- Sub-module mem_lane_align (combinational) takes size, addr[1:0], wdata and mem rdata. It produces wstrb, replicated wdata, aligned rdata and a misaligned flag.

## Test plan
- Data store byte: addr 0x103, wdata 0xAB, ready after 1 cycle → wstrb 1000, mem_wdata 0xABABABAB, o_mem_addr 0x100, o_d_valid in cycle 2.
- Load half: addr 0x202, mem returns 0xBEEF1234 → o_d_rdata 0x0000BEEF, strobes 1100, we = 0.
- Contention: both reqs held continuously, ready immediate → grant order D, IF, D, IF, with one valid every 2 cycles.
- Misaligned word: addr 0x001 → no o_mem_req, o_d_valid + o_d_err the next cycle.
- Timeout: TIMEOUT = 4, ready never asserted → valid with err after 4 BUSY cycles, then IDLE.
- Reset: assert i_rst_n = 0 in the second BUSY cycle → all outputs 0 at once, no valid pulse after release.
